// File: rtl/pmesh_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pmesh_pkg : pmesh NoC2/NoC3 channel types and tracker helpers. Rev 1.0   |
// +--------------------------------------------------------------------------+
package pmesh_pkg;

  localparam int DCP_MSHRID_WIDTH = 8;
  localparam int CH_IDX_W         = 8;
  localparam int MAX_MSHR         = 1 << DCP_MSHRID_WIDTH;

  typedef logic [DCP_MSHRID_WIDTH-1:0] mshrid_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  msg_type;
    mshrid_t     mshrid;
    logic [39:0] addr;
    logic [2:0]  data_size;
    logic [63:0] data;
  } pmesh_noc2_o_t;

  typedef struct packed {
    logic ready;
  } pmesh_noc2_i_t;

  typedef struct packed {
    logic        valid;
    mshrid_t     mshrid;
    logic [63:0] resp_data;
  } pmesh_noc3_in_t;

  // Upper bits of ch stay zero when NUM_CH is small.
  typedef struct packed {
    logic                valid;
    logic [CH_IDX_W-1:0] ch;
    mshrid_t             mshrid;
  } trk_entry_t;

  function automatic logic [DCP_MSHRID_WIDTH-1:0] lowest_set_idx(input logic [MAX_MSHR-1:0] vec);
    lowest_set_idx = '0;
    for (int i = MAX_MSHR - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set_idx = DCP_MSHRID_WIDTH'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/pmesh_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pmesh_rr_arb : round-robin arbiter, one-hot grant. Rev 1.0               |
// +--------------------------------------------------------------------------+
module pmesh_rr_arb #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_en,
  output logic [NUM_CH-1:0] o_gnt
);

  generate
    if (NUM_CH == 1) begin : g_single
      assign o_gnt = i_req & {NUM_CH{i_en}};
    end else begin : g_multi
      localparam int c_ptr_w = $clog2(NUM_CH);

      // r_ptr is the highest-priority channel for the next grant.
      logic [c_ptr_w-1:0] r_ptr;
      logic [c_ptr_w-1:0] w_win;
      logic               w_any;
      int                 w_idx;

      always_comb begin
        w_win = r_ptr;
        w_any = 1'b0;
        w_idx = 0;
        o_gnt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
          w_idx = int'(r_ptr) + k;
          if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
          if (!w_any && i_req[w_idx]) begin
            w_any = 1'b1;
            w_win = c_ptr_w'(w_idx);
          end
        end
        if (w_any && i_en) o_gnt[w_win] = 1'b1;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_ptr <= '0;
        end else if (i_en && w_any) begin
          r_ptr <= (w_win == c_ptr_w'(NUM_CH - 1)) ? '0 : w_win + c_ptr_w'(1);
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pmesh_noc_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pmesh_noc_mux : NUM_CH-client NoC2 mux with mshrid remap and NoC3 route. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pmesh_noc_mux
  import pmesh_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int NUM_MSHR  = 8,
  parameter int MSHR_BASE = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  pmesh_noc2_o_t                 cli_req_i  [NUM_CH],
  output pmesh_noc2_i_t                 cli_req_o  [NUM_CH],
  output pmesh_noc3_in_t                cli_resp_o [NUM_CH],
  output pmesh_noc2_o_t                 noc2_o,
  input  pmesh_noc2_i_t                 noc2_i,
  input  pmesh_noc3_in_t                noc3_i,
  output logic [$clog2(NUM_MSHR+1)-1:0] outstanding_o,
  output logic                          err_o
);

  localparam int c_ch_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_idx_w = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
  localparam int c_cnt_w = $clog2(NUM_MSHR + 1);

  pmesh_noc2_o_t       r_stage;
  trk_entry_t          r_trk  [NUM_MSHR];
  pmesh_noc3_in_t      r_resp [NUM_CH];
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_err;

  logic [NUM_CH-1:0]   w_req;
  logic [NUM_CH-1:0]   w_gnt;
  logic [NUM_MSHR-1:0] w_free;
  logic                w_arb_en;
  logic                w_hs;
  logic [c_ch_w-1:0]   w_win;
  logic [c_idx_w-1:0]  w_alloc;
  logic [c_idx_w-1:0]  w_rsp_idx;
  pmesh_noc2_o_t       w_load;
  trk_entry_t          w_rsp_ent;
  logic                w_rsp_in_rng;
  logic                w_rsp_hit;
  logic                w_drop;
  int                  w_rsp_off;

  // Free vector comes from registered entries, so a slot released this cycle
  // only becomes allocatable on the next one.
  always_comb begin
    w_free = '0;
    w_req  = '0;
    for (int k = 0; k < NUM_MSHR; k++) w_free[k] = !r_trk[k].valid;
    for (int i = 0; i < NUM_CH; i++)   w_req[i]  = cli_req_i[i].valid;
    w_arb_en = !reset && (!r_stage.valid || noc2_i.ready) && (|w_free);
  end

  pmesh_rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .i_req (w_req),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_hs  = |w_gnt;
    w_win = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_gnt[i]) w_win = c_ch_w'(i);
      cli_req_o[i].ready = w_gnt[i];
    end
    w_alloc       = c_idx_w'(lowest_set_idx(MAX_MSHR'(w_free)));
    w_load        = cli_req_i[w_win];
    w_load.valid  = 1'b1;
    w_load.mshrid = mshrid_t'(MSHR_BASE + int'(w_alloc));
  end

  always_comb begin
    w_rsp_off    = int'(noc3_i.mshrid) - MSHR_BASE;
    w_rsp_in_rng = (w_rsp_off >= 0) && (w_rsp_off < NUM_MSHR);
    w_rsp_idx    = c_idx_w'(w_rsp_off);
    w_rsp_ent    = r_trk[w_rsp_idx];
    w_rsp_hit    = noc3_i.valid && w_rsp_in_rng && w_rsp_ent.valid;
    w_drop       = noc3_i.valid && !w_rsp_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage <= '0;
    end else if (w_hs) begin
      r_stage <= w_load;
    end else if (noc2_i.ready) begin
      r_stage.valid <= 1'b0;
    end
  end

  // A hit entry is allocated and the alloc target is free, so they never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_MSHR; k++) r_trk[k] <= '0;
    end else begin
      if (w_rsp_hit) r_trk[w_rsp_idx].valid <= 1'b0;
      if (w_hs) begin
        r_trk[w_alloc].valid  <= 1'b1;
        r_trk[w_alloc].ch     <= CH_IDX_W'(w_win);
        r_trk[w_alloc].mshrid <= cli_req_i[w_win].mshrid;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      case ({w_hs, w_rsp_hit})
        2'b10:   r_cnt <= r_cnt + c_cnt_w'(1);
        2'b01:   r_cnt <= r_cnt - c_cnt_w'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) r_resp[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_resp[i] <= '0;
        if (w_rsp_hit && (w_rsp_ent.ch == CH_IDX_W'(i))) begin
          r_resp[i].valid     <= 1'b1;
          r_resp[i].mshrid    <= w_rsp_ent.mshrid;
          r_resp[i].resp_data <= noc3_i.resp_data;
        end
      end
    end
  end

  assign noc2_o        = r_stage;
  assign outstanding_o = r_cnt;
  assign err_o         = r_err;
  assign cli_resp_o    = r_resp;

endmodule
`default_nettype wire
